// File: rtl/mod_memaccess_pkg.sv
// Shared types and constants for the memory-access stage and its decode helper.
package mod_memaccess_pkg;

    typedef struct packed {
        logic [0:63] pc_contents;
        logic [0:63] alu_result;
        logic [0:63] alu_ext_result;
        logic [0:63] store_data;
        logic [0:63] mem_addr;
        logic [0:7]  ctl_opcode;
        logic        twob_opcode;
        logic [0:2]  ctl_regByte;
        logic [0:2]  ctl_rmByte;
        logic [0:1]  mod;
        logic        sim_end;
    } EX_MEM;

    typedef struct packed {
        logic [0:63] pc_contents;
        logic [0:63] alu_result;
        logic [0:63] alu_ext_result;
        logic [0:7]  ctl_opcode;
        logic        twob_opcode;
        logic [0:2]  ctl_regByte;
        logic [0:2]  ctl_rmByte;
        logic [0:1]  mod;
        logic        sim_end;
    } EX_WB;

    localparam logic [0:7] OP_LOAD       = 8'd139;
    localparam logic [0:7] OP_STORE      = 8'd137;
    localparam logic [0:7] OP_RETQ       = 8'd195;
    localparam logic [0:7] OP_CALL       = 8'd232;
    localparam logic [0:7] OP_CALLI      = 8'd255;
    localparam logic [0:7] OP_PUSH_FIRST = 8'd80;
    localparam logic [0:7] OP_PUSH_LAST  = 8'd87;
    localparam logic [0:7] OP_POP_FIRST  = 8'd88;
    localparam logic [0:7] OP_POP_LAST   = 8'd95;
    localparam logic [0:1] MOD_REGISTER  = 2'd3;

    typedef enum logic {
        IDLE,
        REQ
    } memacc_state_e;

    function automatic EX_WB to_exwb(input EX_MEM m);
        EX_WB w;
        w.pc_contents    = m.pc_contents;
        w.alu_result     = m.alu_result;
        w.alu_ext_result = m.alu_ext_result;
        w.ctl_opcode     = m.ctl_opcode;
        w.twob_opcode    = m.twob_opcode;
        w.ctl_regByte    = m.ctl_regByte;
        w.ctl_rmByte     = m.ctl_rmByte;
        w.mod            = m.mod;
        w.sim_end        = m.sim_end;
        return w;
    endfunction

endpackage

// File: rtl/mod_memop_decode.sv
// Classifies an op as a memory load, a memory store, or neither.
module mod_memop_decode
    import mod_memaccess_pkg::*;
(
    input  logic [0:7] opcode,
    input  logic       twob_opcode,
    input  logic [0:1] mod,
    output logic       is_load,
    output logic       is_store
);

    // Register-direct MOV forms (mod==3) never touch memory; two-byte opcodes are all pass-through.
    always_comb begin
        is_load  = 1'b0;
        is_store = 1'b0;
        if (!twob_opcode) begin
            is_load  = (opcode == OP_LOAD && mod != MOD_REGISTER)
                     || (opcode >= OP_POP_FIRST && opcode <= OP_POP_LAST)
                     || (opcode == OP_RETQ);
            is_store = (opcode == OP_STORE && mod != MOD_REGISTER)
                     || (opcode >= OP_PUSH_FIRST && opcode <= OP_PUSH_LAST)
                     || (opcode == OP_CALL)
                     || (opcode == OP_CALLI);
        end
    end

endmodule

// File: rtl/mod_memaccess.sv
// Memory-access stage: passes ALU results through or runs one req/ack memory
// transaction, then hands a registered bundle to writeback.
module mod_memaccess
    import mod_memaccess_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        can_memory,
    input  EX_MEM       exmem,
    output logic        mem_ready,
    output logic        mem_req,
    output logic        mem_we,
    output logic [0:63] mem_addr,
    output logic [0:63] mem_wdata,
    input  logic        mem_ack,
    input  logic [0:63] mem_rdata,
    output EX_WB        exwb,
    output logic        can_writeback,
    output logic        store_memstage_active,
    output logic        mem_err
);

    localparam logic [15:0] TIMEOUT_LAST = 16'(TIMEOUT_CYCLES - 1);

    memacc_state_e state;
    memacc_state_e next_state;

    logic        is_load;
    logic        is_store;
    logic        fire;
    logic        fire_mem;
    logic        timed_out;
    logic [15:0] counter;
    EX_WB        pending;

    mod_memop_decode u_decode (
        .opcode      (exmem.ctl_opcode),
        .twob_opcode (exmem.twob_opcode),
        .mod         (exmem.mod),
        .is_load     (is_load),
        .is_store    (is_store)
    );

    assign fire      = can_memory && mem_ready;
    assign fire_mem  = fire && (is_load || is_store);
    assign timed_out = (state == REQ) && !mem_ack && (counter == TIMEOUT_LAST);

    always_ff @(posedge clk) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE: if (fire_mem) next_state = REQ;
            REQ:  if (mem_ack || timed_out) next_state = IDLE;
        endcase
    end

    always_comb begin
        mem_ready = (state == IDLE);
        mem_req   = (state == REQ);
    end

    // mem_we doubles as the "pending op is a store" flag for the retire step.
    always_ff @(posedge clk) begin
        if (!reset) begin
            mem_we                <= 1'b0;
            mem_addr              <= '0;
            mem_wdata             <= '0;
            exwb                  <= '0;
            pending               <= '0;
            can_writeback         <= 1'b0;
            store_memstage_active <= 1'b0;
            mem_err               <= 1'b0;
            counter               <= '0;
        end else begin
            can_writeback         <= 1'b0;
            store_memstage_active <= 1'b0;
            case (state)
                IDLE: begin
                    if (fire_mem) begin
                        pending   <= to_exwb(exmem);
                        mem_we    <= is_store;
                        mem_addr  <= exmem.mem_addr;
                        mem_wdata <= exmem.store_data;
                        counter   <= '0;
                    end else if (fire) begin
                        exwb          <= to_exwb(exmem);
                        can_writeback <= 1'b1;
                    end
                end
                REQ: begin
                    if (mem_ack) begin
                        exwb <= pending;
                        if (!mem_we) exwb.alu_result <= mem_rdata;
                        can_writeback         <= 1'b1;
                        store_memstage_active <= mem_we;
                    end else if (timed_out) begin
                        exwb          <= pending;
                        exwb.sim_end  <= 1'b1;
                        mem_err       <= 1'b1;
                        can_writeback <= 1'b1;
                    end else begin
                        counter <= counter + 16'd1;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mod_memaccess.sv
// Randomized self-checking bench for mod_memaccess against a transaction-level model.
module tb_mod_memaccess;
    import mod_memaccess_pkg::*;

    localparam int TIMEOUT = 4;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        can_memory = 1'b0;
    EX_MEM       exmem;
    logic        mem_ready;
    logic        mem_req;
    logic        mem_we;
    logic [0:63] mem_addr;
    logic [0:63] mem_wdata;
    logic        mem_ack = 1'b0;
    logic [0:63] mem_rdata = '0;
    EX_WB        exwb;
    logic        can_writeback;
    logic        store_memstage_active;
    logic        mem_err;

    int   vectors = 0;
    int   miscompares = 0;
    logic err_model = 1'b0;

    always #5 clk = ~clk;

    mod_memaccess #(.TIMEOUT_CYCLES(TIMEOUT)) dut (
        .clk                   (clk),
        .reset                 (reset),
        .can_memory            (can_memory),
        .exmem                 (exmem),
        .mem_ready             (mem_ready),
        .mem_req               (mem_req),
        .mem_we                (mem_we),
        .mem_addr              (mem_addr),
        .mem_wdata             (mem_wdata),
        .mem_ack               (mem_ack),
        .mem_rdata             (mem_rdata),
        .exwb                  (exwb),
        .can_writeback         (can_writeback),
        .store_memstage_active (store_memstage_active),
        .mem_err               (mem_err)
    );

    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        vectors++;
        if (observed !== expected) begin
            miscompares++;
            $display("[TB] FAIL %s: got %h, expected %h", tag, observed, expected);
        end
    endtask

    task automatic nextCycle();
        @(posedge clk);
        #1;
    endtask

    // 0 = pass-through, 1 = load, 2 = store
    function automatic int classify(input EX_MEM op);
        int o;
        o = int'(op.ctl_opcode);
        if (op.twob_opcode) return 0;
        if ((o == 139 && op.mod != 2'd3) || (o >= 88 && o <= 95) || o == 195) return 1;
        if ((o == 137 && op.mod != 2'd3) || (o >= 80 && o <= 87) || o == 232 || o == 255) return 2;
        return 0;
    endfunction

    function automatic EX_MEM mkOp(input logic [7:0] opc, input logic twob, input logic [1:0] md,
                                   input logic [63:0] alu, input logic [63:0] sdata,
                                   input logic [63:0] addr, input logic send);
        EX_MEM m;
        m.pc_contents    = {$urandom, $urandom};
        m.alu_result     = alu;
        m.alu_ext_result = {$urandom, $urandom};
        m.store_data     = sdata;
        m.mem_addr       = addr;
        m.ctl_opcode     = opc;
        m.twob_opcode    = twob;
        m.ctl_regByte    = 3'($urandom);
        m.ctl_rmByte     = 3'($urandom);
        m.mod            = md;
        m.sim_end        = send;
        return m;
    endfunction

    function automatic EX_MEM randomOp();
        logic [7:0] opc;
        case ($urandom_range(0, 9))
            0: opc = 8'd139;
            1: opc = 8'd137;
            2: opc = 8'(88 + $urandom_range(0, 7));
            3: opc = 8'(80 + $urandom_range(0, 7));
            4: opc = 8'd195;
            5: opc = 8'd232;
            6: opc = 8'd255;
            default: opc = 8'($urandom);
        endcase
        return mkOp(opc, ($urandom_range(0, 7) == 0), 2'($urandom), {$urandom, $urandom},
                    {$urandom, $urandom}, {$urandom, $urandom}, ($urandom_range(0, 9) == 0));
    endfunction

    // Offers one op, drives the memory side, and checks every cycle until its writeback.
    task automatic applyStimulus(input EX_MEM op, input int ack_cycle, input logic [63:0] rdata, input bit chain);
        int          cls;
        int          d;
        bit          timeout;
        logic [63:0] exp_alu;
        logic        exp_end;
        logic        exp_store;
        cls     = classify(op);
        timeout = (cls != 0) && !(ack_cycle >= 1 && ack_cycle <= TIMEOUT);
        if (cls == 0) d = 1;
        else if (timeout) d = TIMEOUT + 1;
        else d = ack_cycle + 1;
        exp_alu   = op.alu_result;
        exp_end   = op.sim_end;
        exp_store = 1'b0;
        if (timeout) begin
            exp_end   = 1'b1;
            err_model = 1'b1;
        end else if (cls == 1) begin
            exp_alu = rdata;
        end else if (cls == 2) begin
            exp_store = 1'b1;
        end

        checkOutput("ready_before", mem_ready, 1);
        exmem      = op;
        can_memory = 1'b1;
        mem_ack    = 1'($urandom_range(0, 1));
        mem_rdata  = {$urandom, $urandom};
        nextCycle();
        can_memory     = 1'b0;
        exmem.mem_addr = {$urandom, $urandom};
        exmem.store_data = {$urandom, $urandom};

        for (int c = 1; c < d; c++) begin
            checkOutput("wb_early", can_writeback, 0);
            checkOutput("store_early", store_memstage_active, 0);
            checkOutput("req_busy", mem_req, 1);
            checkOutput("ready_busy", mem_ready, 0);
            checkOutput("we", mem_we, (cls == 2));
            checkOutput("addr", mem_addr, op.mem_addr);
            if (cls == 2) checkOutput("wdata", mem_wdata, op.store_data);
            mem_ack   = (c == ack_cycle);
            mem_rdata = mem_ack ? rdata : {$urandom, $urandom};
            nextCycle();
        end

        mem_ack = 1'b0;
        checkOutput("wb_pulse", can_writeback, 1);
        checkOutput("wb_alu", exwb.alu_result, exp_alu);
        checkOutput("wb_simend", exwb.sim_end, exp_end);
        checkOutput("wb_pc", exwb.pc_contents, op.pc_contents);
        checkOutput("wb_store", store_memstage_active, exp_store);
        checkOutput("mem_err", mem_err, err_model);
        checkOutput("req_done", mem_req, 0);
        checkOutput("ready_done", mem_ready, 1);

        if (!chain) begin
            mem_ack = 1'($urandom_range(0, 1));
            nextCycle();
            mem_ack = 1'b0;
            checkOutput("wb_single", can_writeback, 0);
            checkOutput("store_single", store_memstage_active, 0);
            checkOutput("req_idle", mem_req, 0);
        end
    endtask

    initial begin
        EX_MEM op;
        exmem = '0;
        reset = 1'b0;
        repeat (3) nextCycle();
        checkOutput("rst_req", mem_req, 0);
        checkOutput("rst_wb", can_writeback, 0);
        checkOutput("rst_err", mem_err, 0);
        checkOutput("rst_addr", mem_addr, 0);
        checkOutput("rst_wdata", mem_wdata, 0);
        checkOutput("rst_exwb", exwb.alu_result, 0);
        reset = 1'b1;
        nextCycle();
        checkOutput("ready_after_rst", mem_ready, 1);

        applyStimulus(mkOp(8'd1, 1'b0, 2'd3, 64'h5, 64'h0, 64'h0, 1'b0), 0, 64'h0, 1'b0);
        applyStimulus(mkOp(8'd139, 1'b0, 2'd0, 64'h1, 64'h0, 64'h1000, 1'b0), 3, 64'hDEADBEEF, 1'b0);
        applyStimulus(mkOp(8'h50, 1'b0, 2'd0, 64'h7, 64'h42, 64'h7FF8, 1'b0), 1, 64'h0, 1'b0);
        applyStimulus(mkOp(8'd139, 1'b1, 2'd0, 64'h99, 64'h0, 64'h0, 1'b1), 1, 64'h0, 1'b0);
        applyStimulus(mkOp(8'd137, 1'b0, 2'd3, 64'h33, 64'h0, 64'h0, 1'b0), 1, 64'h0, 1'b0);
        applyStimulus(mkOp(8'd139, 1'b0, 2'd1, 64'h11, 64'h0, 64'h2000, 1'b0), 0, 64'h0, 1'b0);

        // Store abandoned by reset in its second request cycle.
        op = mkOp(8'd232, 1'b0, 2'd0, 64'h8, 64'h1234, 64'h3000, 1'b0);
        exmem      = op;
        can_memory = 1'b1;
        nextCycle();
        can_memory = 1'b0;
        nextCycle();
        checkOutput("rst_mid_req_before", mem_req, 1);
        reset = 1'b0;
        nextCycle();
        err_model = 1'b0;
        checkOutput("rst_mid_req", mem_req, 0);
        checkOutput("rst_mid_wb", can_writeback, 0);
        checkOutput("rst_mid_err", mem_err, 0);
        reset = 1'b1;
        nextCycle();
        checkOutput("rst_mid_wb_after", can_writeback, 0);
        applyStimulus(mkOp(8'd2, 1'b0, 2'd3, 64'hABC, 64'h0, 64'h0, 1'b0), 0, 64'h0, 1'b0);

        // PASS op offered in the writeback cycle of a load.
        applyStimulus(mkOp(8'd88, 1'b0, 2'd3, 64'h0, 64'h0, 64'h4000, 1'b0), 2, 64'hCAFE, 1'b1);
        applyStimulus(mkOp(8'd5, 1'b0, 2'd3, 64'h77, 64'h0, 64'h0, 1'b0), 0, 64'h0, 1'b0);

        for (int i = 0; i < 150; i++) begin
            applyStimulus(randomOp(), $urandom_range(1, TIMEOUT + 2), {$urandom, $urandom},
                          1'($urandom_range(0, 1)));
        end
        nextCycle();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/mod_memaccess.md
# mod_memaccess

Memory-access stage between execute and `mod_writeback`. Accepts one execute-stage result per cycle and classifies it as load, store or pass-through. Runs one 64-bit memory transaction over a req/ack port for loads and stores. Registers the `EX_WB` bundle and pulses `can_writeback` one cycle after the work completes, stalling execute while a transaction is outstanding.

## Interface
Parameters:
- `TIMEOUT_CYCLES`, 255: maximum cycles `mem_req` is held without `mem_ack` before the stage aborts.

Ports (clock and reset first):
- `clk` input 1: the single clock; everything is sampled on its rising edge.
- `reset` input 1: reset is synchronous and active-low.
- `can_memory` input 1: execute presents a valid `exmem` this cycle.
- `exmem` input `EX_MEM`: `pc_contents`, `alu_result`, `alu_ext_result`, `store_data`, `mem_addr`, `ctl_opcode`, `twob_opcode`, `ctl_regByte`, `ctl_rmByte`, `mod`, `sim_end`.
- `mem_ready` output 1: stage can accept; the transfer fires when `can_memory && mem_ready`.
- `mem_req` output 1: memory request, held until acknowledged.
- `mem_we` output 1: 1 = write, 0 = read; valid while `mem_req` is high.
- `mem_addr` output [0:63]: transaction address.
- `mem_wdata` output [0:63]: store data.
- `mem_ack` input 1: transaction complete; read data is valid in the same cycle.
- `mem_rdata` input [0:63]: read data.
- `exwb` output `EX_WB`: registered bundle to writeback.
- `can_writeback` output 1: one-cycle pulse; `exwb` is valid.
- `store_memstage_active` output 1: pulses with `can_writeback` when the retiring op was a completed store-class write.
- `mem_err` output 1: sticky; set when a transaction times out.

## Operation
Classification of an accepted `exmem`:
- **LOAD**: opcode 139 with `mod`≠3, opcodes 88–95 (POP), opcode 195 (RETQ), all with `twob_opcode`=0.
- **STORE**: opcode 137 with `mod`≠3, opcodes 80–87 (PUSH), opcodes 232 and 255 (CALL), all with `twob_opcode`=0.
- **PASS**: everything else, including any op with `twob_opcode`=1.

State machine, `IDLE` and `REQ`:
- **IDLE**, `mem_ready`=1.
  - On a PASS transfer: copy the fields into `exwb` and set `can_writeback` for the next cycle. Stay in IDLE.
  - On a LOAD or STORE transfer: latch the bundle, drive `mem_req`=1, `mem_we`, `mem_addr`=`exmem.mem_addr`, and `mem_wdata`=`exmem.store_data`. Clear the timeout counter and go to REQ.
- **REQ**, `mem_ready`=0, `mem_req`=1.
  - On `mem_ack`: for a LOAD, `exwb.alu_result` ← `mem_rdata`; for a STORE, `alu_result` passes through. Drop `mem_req`, pulse `can_writeback` next cycle (plus `store_memstage_active` for a STORE), and return to IDLE.
  - If there is no `mem_ack` and the counter reaches `TIMEOUT_CYCLES`: set `mem_err`, drop `mem_req`, emit `exwb` with `sim_end`=1 and `can_writeback`=1, and return to IDLE.
- `exmem.sim_end`=1 on a PASS op propagates unchanged.
- `mem_ack` outside REQ is ignored.
- Outputs change only on the clock edge. The `mem_*` outputs are held stable for the whole time `mem_req` is high.

## Timing
- Reset values (`reset`=0 at an edge): state IDLE, `mem_req`=0, `mem_we`=0, `mem_addr`=0, `mem_wdata`=0, `exwb`=0, `can_writeback`=0, `store_memstage_active`=0, `mem_err`=0, counter=0.
- Reset asserted in REQ abandons the transaction: `mem_req` is low after that edge and there is no writeback.
- `mem_ready` is 1 from the first cycle after reset deasserts.
- PASS latency: transfer at edge N gives `can_writeback` high during cycle N+1.
- Memory latency: transfer at edge N puts `mem_req` high in cycle N+1. With `mem_ack` first high in cycle N+k, `can_writeback` is high in cycle N+k+1. The minimum is 2 cycles, when `mem_ack` arrives in the first request cycle.
- `mem_ready` returns to 1 in the same cycle `can_writeback` pulses. A transfer in that cycle is legal, so back-to-back throughput is 1/(k+1).
- Timeout: `mem_err` and `can_writeback` rise in the cycle after the `TIMEOUT_CYCLES`-th cycle of `mem_req` without `mem_ack`.
- `can_writeback` is never high for two consecutive cycles for the same op.

## Structure
- The shared package holds:
  - the `EX_MEM` and `EX_WB` typedefs (`EX_WB` unchanged from the writeback stage's definition);
  - opcode constants (`OP_LOAD`=139, `OP_STORE`=137, `OP_RETQ`=195, `OP_CALL`=232, `OP_CALLI`=255, PUSH/POP ranges);
  - the `memacc_state_e` enum.
- One combinational sub-module, `mod_memop_decode`, takes `opcode`, `twob_opcode` and `mod` and returns `{is_load, is_store}`. The writeback-side decode can reuse it later.

## Test plan
- PASS add (opcode 1, `alu_result`=0x5, `rmByte`=3) → `can_writeback` one cycle later, `exwb.alu_result`=0x5, `mem_req` never rises.
- LOAD (139, `mod`=0, `mem_addr`=0x1000), `mem_ack` after 3 cycles with `mem_rdata`=0xDEADBEEF → `mem_we`=0, `mem_ready`=0 throughout, `exwb.alu_result`=0xDEADBEEF, `store_memstage_active`=0.
- PUSH (0x50, `store_data`=0x42, `mem_addr`=0x7FF8), ack in the first cycle → `mem_we`=1, `mem_wdata`=0x42, `can_writeback` and `store_memstage_active` pulse together at latency 2.
- LOAD with `mem_ack` held low, `TIMEOUT_CYCLES`=4 → `mem_req` drops after 4 cycles, then `mem_err`=1 and `exwb.sim_end`=1.
- Reset driven low in the second REQ cycle of a STORE → `mem_req`=0 and `can_writeback`=0 after the edge. A PASS op presented after reset completes normally.
- Back-to-back: a PASS op offered in the `can_writeback` cycle of a LOAD → accepted, and its writeback pulse follows one cycle later.
